switch_allocator: RTL and testbench

- Per-cycle output-port allocator; sits directly downstream of rcu in each 3D mesh router.
- Consumes the six per-input port_t directions from rcu, plus head/tail flags from the input buffers.
- Arbitrates each of the six output ports round-robin, holds each output for one wormhole packet from head to tail, and drives the crossbar selects and input-buffer pops.
- Fault-aware on the vertical (TSV) outputs.

---
 rtl/rcu_header.sv | 45 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/switch_allocator.sv | 138 +++++++++++++
 tb/tb_switch_allocator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rcu_header.sv
// Shared router definitions: port directions, mesh position, port count,
// per-port bit vector type and direction helpers used by the router
// control blocks (rcu, switch_allocator).
// No ports (package).
package rcu_header;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    UP    = 3'd4,
    DOWN  = 3'd5
  } port_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } position_t;

  localparam int N_PORTS = 6;

  typedef logic [N_PORTS-1:0] port_vec_t;

  // Direction a flit leaving through p would arrive from at the neighbour.
  function automatic port_t opposite(input port_t p);
    case (p)
      NORTH:   return SOUTH;
      SOUTH:   return NORTH;
      EAST:    return WEST;
      WEST:    return EAST;
      UP:      return DOWN;
      DOWN:    return UP;
      default: return p;
    endcase
  endfunction

  // Round-robin successor, wrapping DOWN back to NORTH.
  function automatic port_t next_port(input port_t p);
    if (p >= DOWN) return NORTH;
    return port_t'(3'(p + 3'd1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 6-way round-robin picker. Scans req starting at index ptr
// and wrapping; the first set request wins.
// Ports:
//   req     in  6-bit request vector
//   ptr     in  highest-priority index this cycle (0..5)
//   gnt     out one-hot grant (all zero when no request)
//   gnt_idx out index of the granted request (NORTH when none)
module rr_arbiter
  import rcu_header::*;
(
  input  port_vec_t req,
  input  port_t     ptr,
  output port_vec_t gnt,
  output port_t     gnt_idx
);

  logic [2:0] w_idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = NORTH;
    w_idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      w_idx = 3'((int'(ptr) + k) % N_PORTS);
      if (req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        gnt_idx    = port_t'(w_idx);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-cycle output-port allocator for a 3D mesh router. Each output is
// arbitrated round-robin among legal head flits while idle, then held for
// its owner until the tail flit passes (wormhole). Idle UP/DOWN outputs
// refuse new heads while their TSV link is faulty; a packet already locked
// on them drains normally. Illegal flits are never granted and set a
// sticky error flag.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/dir/head/tail  per-input flit at buffer head and its route
//   out_ready         per-output downstream credit available
//   up_faulty/down_faulty    vertical link fault flags
//   grant             per-input buffer pop
//   xbar_sel/xbar_valid      per-output crossbar select and flit valid
//   lock_busy         per-output mid-packet lock state
//   proto_err         sticky protocol error
module switch_allocator
  import rcu_header::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  port_vec_t             req_valid,
  input  port_t [N_PORTS-1:0]   req_dir,
  input  port_vec_t             req_head,
  input  port_vec_t             req_tail,
  input  port_vec_t             out_ready,
  input  logic                  up_faulty,
  input  logic                  down_faulty,
  output port_vec_t             grant,
  output port_t [N_PORTS-1:0]   xbar_sel,
  output port_vec_t             xbar_valid,
  output port_vec_t             lock_busy,
  output logic                  proto_err
);

  port_vec_t           r_lock_valid;
  port_t [N_PORTS-1:0] r_lock_owner;
  port_t [N_PORTS-1:0] r_rr_ptr;
  logic                r_proto_err;

  port_vec_t w_err;
  port_vec_t w_blocked;
  port_vec_t w_req     [N_PORTS];
  port_vec_t w_gnt     [N_PORTS];
  port_t     w_gnt_idx [N_PORTS];

  // Illegal flits: bad direction, U-turn, or a body/tail flit that does not
  // own the lock of the output it names. A head meeting someone else's lock
  // is legal and simply waits.
  always_comb begin
    w_err = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (req_valid[i]) begin
        if (req_dir[i] > DOWN)
          w_err[i] = 1'b1;
        else if (int'(req_dir[i]) == i)
          w_err[i] = 1'b1;
        else if (!req_head[i] &&
                 !(r_lock_valid[req_dir[i]] && int'(r_lock_owner[req_dir[i]]) == i))
          w_err[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_blocked = ~out_ready;
    w_blocked[UP]   = w_blocked[UP]   | (up_faulty   & ~r_lock_valid[UP]);
    w_blocked[DOWN] = w_blocked[DOWN] | (down_faulty & ~r_lock_valid[DOWN]);
  end

  // While locked only the owner's body/tail flit can be eligible, so the
  // arbiter trivially picks the owner.
  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        if (req_valid[i] && !w_err[i] && !w_blocked[o] && int'(req_dir[i]) == o) begin
          if (r_lock_valid[o])
            w_req[o][i] = (int'(r_lock_owner[o]) == i) && !req_head[i];
          else
            w_req[o][i] = req_head[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter u_arb (
      .req     (w_req[g]),
      .ptr     (r_rr_ptr[g]),
      .gnt     (w_gnt[g]),
      .gnt_idx (w_gnt_idx[g])
    );
  end

  always_comb begin
    grant      = '0;
    xbar_valid = '0;
    for (int o = 0; o < N_PORTS; o++) xbar_sel[o] = NORTH;
    if (!reset) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (|w_gnt[o]) begin
          xbar_valid[o] = 1'b1;
          xbar_sel[o]   = w_gnt_idx[o];
          grant         = grant | w_gnt[o];
        end
      end
    end
    lock_busy = reset ? '0 : r_lock_valid;
    proto_err = r_proto_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_valid <= '0;
      r_proto_err  <= 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        r_lock_owner[o] <= NORTH;
        r_rr_ptr[o]     <= NORTH;
      end
    end else begin
      if (|w_err) r_proto_err <= 1'b1;
      for (int o = 0; o < N_PORTS; o++) begin
        if (|w_gnt[o]) begin
          // Tail (including head+tail) releases and advances priority;
          // a lone head takes the lock.
          if (req_tail[w_gnt_idx[o]]) begin
            r_lock_valid[o] <= 1'b0;
            r_rr_ptr[o]     <= next_port(w_gnt_idx[o]);
          end else if (req_head[w_gnt_idx[o]]) begin
            r_lock_valid[o] <= 1'b1;
            r_lock_owner[o] <= w_gnt_idx[o];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator. Inputs change on the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_switch_allocator;
  import rcu_header::*;

  logic                clk = 1'b0;
  logic                reset;
  port_vec_t           req_valid;
  port_t [N_PORTS-1:0] req_dir;
  port_vec_t           req_head;
  port_vec_t           req_tail;
  port_vec_t           out_ready;
  logic                up_faulty;
  logic                down_faulty;
  port_vec_t           grant;
  port_t [N_PORTS-1:0] xbar_sel;
  port_vec_t           xbar_valid;
  port_vec_t           lock_busy;
  logic                proto_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_dir     (req_dir),
    .req_head    (req_head),
    .req_tail    (req_tail),
    .out_ready   (out_ready),
    .up_faulty   (up_faulty),
    .down_faulty (down_faulty),
    .grant       (grant),
    .xbar_sel    (xbar_sel),
    .xbar_valid  (xbar_valid),
    .lock_busy   (lock_busy),
    .proto_err   (proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    for (int i = 0; i < N_PORTS; i++) req_dir[i] = NORTH;
  endtask

  task automatic put(input port_t src, input port_t dst, input logic hd, input logic tl);
    req_valid[src] = 1'b1;
    req_dir[src]   = dst;
    req_head[src]  = hd;
    req_tail[src]  = tl;
  endtask

  task automatic drop(input port_t src);
    req_valid[src] = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; up_faulty = 1'b0; down_faulty = 1'b0; out_ready = '1;
    clr();
    put(NORTH, EAST, 1'b1, 1'b1);
    @(negedge clk); #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_xvalid", 32'(xbar_valid), 32'h0);
    check_eq("rst_xsel", 32'(xbar_sel), 32'h0);
    check_eq("rst_lock", 32'(lock_busy), 32'h0);
    @(negedge clk); #1;
    check_eq("rst_perr", 32'(proto_err), 32'h0);

    // Single-flit packets to EAST, rr_ptr starts at NORTH
    @(negedge clk); reset = 1'b0; clr();
    put(SOUTH, EAST, 1'b1, 1'b1); put(WEST, EAST, 1'b1, 1'b1); #1;
    check_eq("sf_grant_south", 32'(grant), 32'h02);
    check_eq("sf_sel_south", 32'(xbar_sel[EAST]), 32'(SOUTH));
    check_eq("sf_xvalid", 32'(xbar_valid), 32'h04);
    @(negedge clk); drop(SOUTH); #1;
    check_eq("sf_grant_west", 32'(grant), 32'h08);
    check_eq("sf_sel_west", 32'(xbar_sel[EAST]), 32'(WEST));
    // rr_ptr[EAST] is now UP (4): NORTH beats SOUTH
    @(negedge clk); clr(); put(NORTH, EAST, 1'b1, 1'b1); put(SOUTH, EAST, 1'b1, 1'b1); #1;
    check_eq("sf_rr_wrap", 32'(grant), 32'h01);
    @(negedge clk); drop(NORTH); #1;
    check_eq("sf_south_next", 32'(grant), 32'h02);

    // Wormhole NORTH->DOWN with EAST head waiting, backpressure mid-packet
    @(negedge clk); clr(); put(NORTH, DOWN, 1'b1, 1'b0); put(EAST, DOWN, 1'b1, 1'b1); #1;
    check_eq("wh_head", 32'(grant), 32'h01);
    check_eq("wh_head_sel", 32'(xbar_sel[DOWN]), 32'(NORTH));
    check_eq("wh_head_lock", 32'(lock_busy), 32'h0);
    @(negedge clk); put(NORTH, DOWN, 1'b0, 1'b0); #1;
    check_eq("wh_body1", 32'(grant), 32'h01);
    check_eq("wh_body1_lock", 32'(lock_busy), 32'h20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); out_ready[DOWN] = 1'b0; #1;
      check_eq("bp_grant", 32'(grant), 32'h0);
      check_eq("bp_xvalid", 32'(xbar_valid), 32'h0);
      check_eq("bp_lock", 32'(lock_busy), 32'h20);
    end
    @(negedge clk); out_ready = '1; #1;
    check_eq("wh_body2", 32'(grant), 32'h01);
    @(negedge clk); put(NORTH, DOWN, 1'b0, 1'b1); #1;
    check_eq("wh_tail", 32'(grant), 32'h01);
    check_eq("wh_tail_lock", 32'(lock_busy), 32'h20);
    @(negedge clk); drop(NORTH); #1;
    check_eq("wh_released", 32'(lock_busy), 32'h0);
    check_eq("wh_east", 32'(grant), 32'h04);
    check_eq("wh_east_sel", 32'(xbar_sel[DOWN]), 32'(EAST));
    @(negedge clk); clr(); #1;
    check_eq("wh_no_err", 32'(proto_err), 32'h0);

    // UP fault handling
    @(negedge clk); up_faulty = 1'b1; put(NORTH, UP, 1'b1, 1'b1); #1;
    check_eq("flt_idle_blk0", 32'(grant), 32'h0);
    @(negedge clk); #1;
    check_eq("flt_idle_blk1", 32'(grant), 32'h0);
    @(negedge clk); up_faulty = 1'b0; #1;
    check_eq("flt_clear", 32'(grant), 32'h01);
    @(negedge clk); clr(); put(SOUTH, UP, 1'b1, 1'b0); #1;
    check_eq("flt_lock_head", 32'(grant), 32'h02);
    @(negedge clk); up_faulty = 1'b1; put(SOUTH, UP, 1'b0, 1'b0); #1;
    check_eq("flt_drain_body", 32'(grant), 32'h02);
    check_eq("flt_drain_lock", 32'(lock_busy), 32'h10);
    @(negedge clk); put(SOUTH, UP, 1'b0, 1'b1); #1;
    check_eq("flt_drain_tail", 32'(grant), 32'h02);
    @(negedge clk); clr(); put(WEST, UP, 1'b1, 1'b1); #1;
    check_eq("flt_refuse", 32'(grant), 32'h0);
    check_eq("flt_unlocked", 32'(lock_busy), 32'h0);
    @(negedge clk); #1;
    check_eq("flt_refuse2", 32'(grant), 32'h0);
    @(negedge clk); clr(); up_faulty = 1'b0; #1;
    check_eq("flt_no_err", 32'(proto_err), 32'h0);

    // Body flit with no lock
    @(negedge clk); put(WEST, NORTH, 1'b0, 1'b0); #1;
    check_eq("pe_body_grant", 32'(grant), 32'h0);
    check_eq("pe_body_pre", 32'(proto_err), 32'h0);
    @(negedge clk); clr(); #1;
    check_eq("pe_body_set", 32'(proto_err), 32'h1);
    @(negedge clk); put(NORTH, SOUTH, 1'b1, 1'b1); #1;
    check_eq("pe_legal_after", 32'(grant), 32'h01);
    check_eq("pe_sticky", 32'(proto_err), 32'h1);

    // Reset with a NORTH->EAST packet in flight (rr_ptr[EAST] is EAST here)
    @(negedge clk); clr(); put(NORTH, EAST, 1'b1, 1'b0); #1;
    check_eq("rl_head", 32'(grant), 32'h01);
    @(negedge clk); put(NORTH, EAST, 1'b0, 1'b0); #1;
    check_eq("rl_body", 32'(grant), 32'h01);
    check_eq("rl_locked", 32'(lock_busy), 32'h04);
    @(negedge clk); reset = 1'b1; #1;
    check_eq("rl_rst_grant", 32'(grant), 32'h0);
    check_eq("rl_rst_xvalid", 32'(xbar_valid), 32'h0);
    check_eq("rl_rst_xsel", 32'(xbar_sel), 32'h0);
    check_eq("rl_rst_lock", 32'(lock_busy), 32'h0);
    @(negedge clk); reset = 1'b0; clr(); #1;
    check_eq("rl_post_lock", 32'(lock_busy), 32'h0);
    check_eq("rl_post_perr", 32'(proto_err), 32'h0);
    @(negedge clk); put(SOUTH, EAST, 1'b1, 1'b1); put(WEST, EAST, 1'b1, 1'b1); #1;
    check_eq("rl_rr_reset", 32'(grant), 32'h02);

    // U-turn head from UP
    @(negedge clk); clr(); put(UP, UP, 1'b1, 1'b1); #1;
    check_eq("ut_grant", 32'(grant), 32'h0);
    @(negedge clk); clr(); #1;
    check_eq("ut_perr", 32'(proto_err), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
